// File: rtl/i2c_color_target_pkg.sv
// Shared definitions for the RGBC colour-sensor I2C target.
// Holds the register map addresses, command byte encodings, default
// device identity and the protocol state enumeration.
package i2c_color_target_pkg;

  // Register map (5-bit pointer space)
  localparam logic [4:0] REG_ENABLE = 5'h00;
  localparam logic [4:0] REG_ID     = 5'h12;
  localparam logic [4:0] REG_STATUS = 5'h13;
  localparam logic [4:0] REG_CDATAL = 5'h14;
  localparam logic [4:0] REG_CDATAH = 5'h15;
  localparam logic [4:0] REG_RDATAL = 5'h16;
  localparam logic [4:0] REG_RDATAH = 5'h17;
  localparam logic [4:0] REG_GDATAL = 5'h18;
  localparam logic [4:0] REG_GDATAH = 5'h19;
  localparam logic [4:0] REG_BDATAL = 5'h1A;
  localparam logic [4:0] REG_BDATAH = 5'h1B;

  // Command byte: bit7 flags a command, bits6:5 select the pointer mode
  localparam int unsigned CMD_BIT  = 7;
  localparam logic [1:0]  AUTO_INC = 2'b01;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h29;
  localparam logic [7:0] DEFAULT_ID_VALUE = 8'h44;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StCmd,
    StCmdAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWait
  } state_e;

endpackage

// File: rtl/i2c_color_target_line_sync.sv
// Line conditioning for the I2C target: 2-FF synchronisers on scl/sda,
// a previous-value register, and bus event detection.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   scl, sda           raw bus lines (asynchronous to clk)
//   scl_rise/scl_fall  one-cycle clock edge events
//   start_det/stop_det one-cycle START / STOP events
//   sda_s              synchronised data line
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl_s;

  // Reset to the idle-bus level so leaving reset creates no false START/STOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_ff   <= 2'b11;
      sda_ff   <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_ff   <= {scl_ff[0], scl};
      sda_ff   <= {sda_ff[0], sda};
      scl_prev <= scl_ff[1];
      sda_prev <= sda_ff[1];
    end
  end

  assign scl_s     = scl_ff[1];
  assign sda_s     = sda_ff[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_color_target.sv
// I2C target modelling an RGBC colour sensor: command/register protocol,
// ENABLE/ID/STATUS registers and eight shadowed channel data bytes.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   scl                      bus clock (input only, never stretched)
//   sda                      bus data, driven only 0 or z
//   sample_valid             strobe capturing clear/red/green/blue
//   clear, red, green, blue  16-bit raw channel values
//   enable                   ENABLE register
//   busy                     addressed and transaction in progress
//   wr_strobe                one-cycle pulse per committed register write
module i2c_color_target
  import i2c_color_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR,
  parameter logic [7:0] ID_VALUE = DEFAULT_ID_VALUE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  input  logic        sample_valid,
  input  logic [15:0] clear,
  input  logic [15:0] red,
  input  logic [15:0] green,
  input  logic [15:0] blue,
  output logic [7:0]  enable,
  output logic        busy,
  output logic        wr_strobe
);

  logic        scl_rise, scl_fall, start_det, stop_det, sda_s;
  state_e      state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  tx;
  logic        rw;
  logic [4:0]  ptr;
  logic        auto_inc;
  logic        sda_oe;
  logic        avalid;
  logic [63:0] shadow;
  logic        pending;
  logic [63:0] pending_data;
  logic [63:0] new_sample;
  logic [7:0]  rd_byte;
  logic [2:0]  sh_idx;
  logic        in_read;

  i2c_line_sync u_line_sync (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  // Gated by rst so the line is released in the reset cycle itself.
  assign sda = (sda_oe && !rst) ? 1'b0 : 1'bz;

  // Byte order matches CL, CH, RL, RH, GL, GH, BL, BH.
  assign new_sample = {blue, green, red, clear};
  assign in_read    = (state == StRdata) || (state == StRdataAck);
  // 0x14..0x1B map onto shadow bytes 0..7
  assign sh_idx     = ptr[2:0] - 3'd4;

  always_comb begin
    rd_byte = 8'h00;
    if (ptr == REG_ENABLE) begin
      rd_byte = enable;
    end else if (ptr == REG_ID) begin
      rd_byte = ID_VALUE;
    end else if (ptr == REG_STATUS) begin
      rd_byte = {7'b0, avalid};
    end else if (ptr >= REG_CDATAL && ptr <= REG_BDATAH) begin
      rd_byte = shadow[{sh_idx, 3'b000} +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      bit_cnt      <= 4'd0;
      shift        <= 8'h00;
      tx           <= 8'h00;
      rw           <= 1'b0;
      ptr          <= 5'd0;
      auto_inc     <= 1'b0;
      sda_oe       <= 1'b0;
      busy         <= 1'b0;
      wr_strobe    <= 1'b0;
      enable       <= 8'h00;
      avalid       <= 1'b0;
      shadow       <= 64'd0;
      pending      <= 1'b0;
      pending_data <= 64'd0;
    end else begin
      wr_strobe <= 1'b0;

      // A read burst in flight keeps its snapshot; the newest sample waits for STOP.
      if (sample_valid) begin
        if (enable[1]) avalid <= 1'b1;
        if (in_read && !stop_det) begin
          pending      <= 1'b1;
          pending_data <= new_sample;
        end else begin
          shadow  <= new_sample;
          pending <= 1'b0;
        end
      end else if (stop_det && pending) begin
        shadow  <= pending_data;
        pending <= 1'b0;
      end

      // Bus conditions take priority over any clock edge in the same cycle.
      if (stop_det) begin
        state  <= StIdle;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_det) begin
        state   <= StAddr;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          StAddr: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shift[7:1] == DEV_ADDR) begin
                state  <= StAddrAck;
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
              end else begin
                state <= StWait;
              end
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                state  <= StRdata;
                tx     <= rd_byte;
                sda_oe <= ~rd_byte[7];
              end else begin
                state  <= StCmd;
                sda_oe <= 1'b0;
              end
            end
          end
          StCmd: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              if (shift[CMD_BIT]) begin
                state    <= StCmdAck;
                sda_oe   <= 1'b1;
                ptr      <= shift[4:0];
                auto_inc <= (shift[6:5] == AUTO_INC);
              end else begin
                state <= StWait;
                busy  <= 1'b0;
              end
            end
          end
          StCmdAck: begin
            if (scl_fall) begin
              state   <= StWdata;
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
            end
          end
          StWdata: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              state  <= StWdataAck;
              sda_oe <= 1'b1;
            end
          end
          StWdataAck: begin
            if (scl_rise) begin
              wr_strobe <= 1'b1;
              if (ptr == REG_ENABLE) begin
                enable <= shift;
                if (!shift[1]) avalid <= 1'b0;
              end
              if (auto_inc) ptr <= ptr + 5'd1;
            end else if (scl_fall) begin
              state   <= StWdata;
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
            end
          end
          StRdata: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                state  <= StRdataAck;
                sda_oe <= 1'b0;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          StRdataAck: begin
            // NACK leaves at the rise, so a fall here always follows an ACK.
            if (scl_rise) begin
              if (sda_s) begin
                state <= StWait;
                busy  <= 1'b0;
              end else if (auto_inc) begin
                ptr <= ptr + 5'd1;
              end
            end else if (scl_fall) begin
              state   <= StRdata;
              bit_cnt <= 4'd0;
              tx      <= rd_byte;
              sda_oe  <= ~rd_byte[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_color_target.md
Name: i2c_color_target

Overview:
- I2C target (slave) responder modelling the RGBC colour sensor. It answers the command/register protocol that the colour-reading I2C initiator uses.
- Two uses: a drop-in sensor model for closed-loop simulation and on-board loopback of the initiator, and an FPGA-hosted sensor for a second board.
- Holds a small register map (ENABLE, ID, STATUS, 8 data bytes) fed by 16-bit clear/red/green/blue inputs.
- Drives SDA open-drain; never drives SCL (no clock stretching).

Parameters:
- DEV_ADDR, 7'h29, 7-bit target address.
- ID_VALUE, 8'h44, value returned at register 0x12.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. Synchronous, active-high.
- scl  input  1  I2C clock from the initiator; asynchronous to clk.
- sda  inout  1  I2C data. Only ever driven 1'b0 or 1'bz.
- sample_valid  input  1  one-cycle strobe: capture clear/red/green/blue into the shadow registers.
- clear, red, green, blue  input  16 each  raw channel values.
- enable  output  8  ENABLE register contents.
- busy  output  1  high from address-match ACK until STOP, repeated START or NACK release.
- wr_strobe  output  1  one-cycle pulse when a register write commits.

Behaviour:
- Line conditioning:
  - scl and sda pass through 2-FF synchronisers, then a previous-value register.
  - Events: scl_rise, scl_fall; START = sda fall while scl high; STOP = sda rise while scl high.
  - Initiator T_LOW of 200 clk makes the ~3-cycle detection latency safe.
- Bit timing:
  - SDA is sampled on scl_rise.
  - SDA drive changes only on scl_fall.
  - Bits are MSB first.
- Register map (5-bit pointer ptr):
  - 0x00 ENABLE: RW.
  - 0x12 ID: RO, returns ID_VALUE.
  - 0x13 STATUS: RO, bit0 = AVALID.
  - 0x14..0x1B: CL, CH, RL, RH, GL, GH, BL, BH, read from the shadow registers.
  - Any other address reads 8'h00; writes to it are ACKed and discarded.
- Command byte (first data byte of a write):
  - bit7 must be 1, otherwise NACK and go to WAIT.
  - bits6:5 = 01: auto-increment. 00: repeated-byte. Other values are treated as 00.
  - bits4:0 load ptr.
- States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT.
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits.
    - Address match: ADDR_ACK, driving SDA=0 from the 8th scl_fall to the 9th scl_fall.
    - Mismatch: WAIT with SDA released.
  - R/W=0 -> CMD. After CMD, go to CMD_ACK (or NACK) and then WDATA.
  - WDATA_ACK:
    - Always ACK.
    - Writes reg[ptr], pulses wr_strobe for 1 cycle on the 9th scl_rise.
    - Increments ptr if auto-increment is set.
  - R/W=1:
    - At the 9th scl_fall of the address byte, load tx byte = reg[ptr] and drive its MSB.
    - RDATA shifts out 8 bits; SDA=z for a 1, 0 for a 0.
    - RDATA_ACK releases SDA and samples on the 9th scl_rise.
      - ACK (0): increment ptr if auto-increment, load the next byte, continue RDATA.
      - NACK (1): WAIT.
  - WAIT: SDA released; ignores bus until START or STOP.
  - STOP in any state -> IDLE, SDA released, busy=0.
  - START in any state -> ADDR (repeated start). ptr is retained.
- ptr wraps 0x1F -> 0x00. Reads beyond 0x1B return 8'h00.
- Shadow/coherency:
  - On sample_valid, latch all four channels, unless state is RDATA or RDATA_ACK. In that case hold one pending capture and apply it at STOP.
  - This guarantees an 8-byte burst is from one sample.
- AVALID:
  - Set on sample_valid when ENABLE[1]=1.
  - Cleared when ENABLE is written with bit1=0.
- Reset mid-transaction:
  - sda released immediately on the reset cycle.
  - State IDLE; enable=0, ptr=0, AVALID=0, shadow=0, busy=0, wr_strobe=0.
  - The target stays in IDLE until the next START.
- Simultaneous scl_fall and START/STOP detection: the START/STOP event wins.

Decomposition:
- Shared package gets:
  - register address constants (REG_ENABLE, REG_ID, REG_STATUS, REG_CDATAL..REG_BDATAH);
  - CMD_BIT, AUTO_INC encodings;
  - default DEV_ADDR and ID_VALUE;
  - the state enum.
- One sub-module: i2c_line_sync. It holds the synchronisers and edge detection, and outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- Write sequence 0x52, 0xA0, 0x03, STOP:
  - three ACKs (SDA=0 at each 9th scl_rise);
  - enable=8'h03;
  - exactly one wr_strobe.
- Shadow set to red=16'h1234, green=16'h5678, blue=16'h9ABC, clear=16'h0011 (ENABLE=0x03). Sequence 0x52, 0xB4, STOP, START, 0x53, 8 reads with ACK, last NACK:
  - bytes returned: 11 00 34 12 78 56 BC 9A;
  - busy falls at NACK/STOP.
- Address 0x54:
  - NACK (SDA=z at 9th scl_rise);
  - bus ignored until STOP;
  - enable unchanged.
- Command byte 0x14 (bit7=0): NACK, no write, ptr unchanged.
- sample_valid with new values mid-burst, after 3 bytes read:
  - remaining bytes still come from the old sample;
  - the new values are visible on the next transaction.
- rst asserted during RDATA driving a 0 bit:
  - sda=z in the same cycle;
  - enable=0;
  - the next 0x52/0xA0/0x03 transaction succeeds.
